move_sequencer: RTL and testbench



---
 rtl/move_seq_pkg.sv | 37 +++
 rtl/move_sequencer_cmd_fifo.sv | 55 +++++
 rtl/move_sequencer.sv | 147 ++++++++++++++
 tb/tb_move_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_seq_pkg.sv
// Shared types for the move sequencer: compass direction codes, FSM state
// encoding and the buffered command entry layout.
package move_seq_pkg;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_NW = 3'd1;
  localparam logic [2:0] DIR_W  = 3'd2;
  localparam logic [2:0] DIR_SW = 3'd3;
  localparam logic [2:0] DIR_S  = 3'd4;
  localparam logic [2:0] DIR_SE = 3'd5;
  localparam logic [2:0] DIR_E  = 3'd6;
  localparam logic [2:0] DIR_NE = 3'd7;

  localparam int CMD_W = 5;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    HOME       = 3'd1,
    HOME_WAIT  = 3'd2,
    LOAD       = 3'd3,
    MAG_SETTLE = 3'd4,
    ISSUE      = 3'd5,
    WAIT_DONE  = 3'd6,
    ERROR      = 3'd7
  } state_t;

  typedef struct packed {
    logic       last;
    logic       magnet;
    logic [2:0] dir;
  } cmd_t;

  function automatic logic [7:0] dir_onehot(input logic [2:0] d);
    return 8'h01 << d;
  endfunction

endpackage

// File: rtl/move_sequencer_cmd_fifo.sv
// Synchronous show-ahead command FIFO; o_rdata always presents the head entry.
module cmd_fifo
  import move_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [CMD_W-1:0]              i_wdata,
  output logic [CMD_W-1:0]              o_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_full,
  output logic                          o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CMD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Buffers compass-move commands and replays them to the motor stage with magnet
// settle and homing. Optional MOVE_TIMEOUT_EN adds a done-wait timeout to ERROR.
module move_sequencer
  import move_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int SETTLE_CYCLES  = 50000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_dir,
  input  logic                        cmd_magnet,
  input  logic                        cmd_last,
  input  logic                        home_req,
  output logic [7:0]                  direction,
  output logic                        motor_reset,
  input  logic                        motor_done,
  input  logic                        motor_reset_done,
  output logic                        magnet_en,
  output logic                        busy,
  output logic                        batch_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        error,
  output logic [2:0]                  dbg_state
);

  localparam logic [31:0] SETTLE_LAST = (SETTLE_CYCLES <= 1) ? 32'd0 : 32'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_next;
  cmd_t       r_cur, w_head;
  logic [4:0] w_rdata;
  logic       w_push, w_pop, w_full, w_empty;
  logic       r_home_pend, r_done_q, r_rdone_q, w_done_rise, w_rdone_rise;
  logic       r_magnet_en;
  logic [31:0] r_settle_cnt;
  logic       w_timeout;

  // Handshake: a command transfers on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on registered state, never on cmd_valid or a pop.
  assign w_push       = cmd_valid & cmd_ready;
  assign w_head       = w_rdata;
  assign w_done_rise  = motor_done & ~r_done_q;
  assign w_rdone_rise = motor_reset_done & ~r_rdone_q;
  assign magnet_en    = r_magnet_en;
  assign dbg_state    = r_state;

  cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({cmd_last, cmd_magnet, cmd_dir}),
    .o_rdata (w_rdata),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef MOVE_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES <= 1) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] r_to_cnt;

  // Restarts from zero on every entry because it is held clear outside the waits.
  always_ff @(posedge clk) begin
    if (reset) r_to_cnt <= '0;
    else if (r_state == WAIT_DONE || r_state == HOME_WAIT) r_to_cnt <= r_to_cnt + 32'd1;
    else r_to_cnt <= '0;
  end
  assign w_timeout = (r_to_cnt == TO_LAST);
  assign error     = (r_state == ERROR);
`else
  assign w_timeout = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       if (r_home_pend) w_state_next = HOME;
                  else if (!w_empty) w_state_next = LOAD;
      HOME:       w_state_next = HOME_WAIT;
      HOME_WAIT:  if (w_rdone_rise) w_state_next = IDLE;
                  else if (w_timeout) w_state_next = ERROR;
      LOAD:       w_state_next = (w_head.magnet != r_magnet_en) ? MAG_SETTLE : ISSUE;
      MAG_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_next = ISSUE;
      ISSUE:      w_state_next = WAIT_DONE;
      WAIT_DONE:  if (w_done_rise) begin
                    if (r_home_pend)   w_state_next = HOME;
                    else if (!w_empty) w_state_next = LOAD;
                    else               w_state_next = IDLE;
                  end else if (w_timeout) w_state_next = ERROR;
      ERROR:      w_state_next = ERROR;
      default:    w_state_next = IDLE;
    endcase
  end

  always_comb begin
    direction   = 8'h00;
    motor_reset = 1'b0;
    batch_done  = 1'b0;
    w_pop       = 1'b0;
    busy        = (r_state != IDLE);
    cmd_ready   = ~w_full & (r_state != ERROR);
    case (r_state)
      HOME:      motor_reset = 1'b1;
      LOAD:      w_pop = 1'b1;
      ISSUE:     direction = dir_onehot(r_cur.dir);
      WAIT_DONE: batch_done = w_done_rise & r_cur.last;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur        <= '0;
      r_home_pend  <= 1'b0;
      r_done_q     <= 1'b0;
      r_rdone_q    <= 1'b0;
      r_settle_cnt <= '0;
      r_magnet_en  <= 1'b0;
    end else begin
      r_done_q  <= motor_done;
      r_rdone_q <= motor_reset_done;
      if (home_req) r_home_pend <= 1'b1;
      else if (w_state_next == HOME && r_state != HOME) r_home_pend <= 1'b0;
      if (r_state == MAG_SETTLE) r_settle_cnt <= r_settle_cnt + 32'd1;
      else                       r_settle_cnt <= '0;
      if (r_state == LOAD) begin
        r_cur       <= w_head;
        r_magnet_en <= w_head.magnet;
      end else if (r_state == HOME || w_state_next == ERROR) begin
        r_magnet_en <= 1'b0;
      end else if (r_state == WAIT_DONE && w_done_rise && r_cur.last) begin
        r_magnet_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: each task drives one scenario and checks
// outputs inline against hand-derived cycle expectations.
module tb_move_sequencer;
  import move_seq_pkg::*;

  localparam int DEPTH   = 16;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_magnet = 1'b0, cmd_last = 1'b0, home_req = 1'b0;
  logic [2:0] cmd_dir = 3'd0;
  logic       motor_done = 1'b0, motor_reset_done = 1'b0;
  logic       cmd_ready, motor_reset, magnet_en, busy, batch_done, error;
  logic [7:0] direction;
  logic [4:0] fifo_count;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int mreset_pulses = 0;
  int dir_pulses = 0;
  logic [7:0] last_pulse = 8'h00;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (motor_reset) mreset_pulses++;
    if (direction != 8'h00) begin
      dir_pulses++;
      last_pulse = direction;
    end
  end

  move_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_magnet(cmd_magnet), .cmd_last(cmd_last),
    .home_req(home_req), .direction(direction), .motor_reset(motor_reset),
    .motor_done(motor_done), .motor_reset_done(motor_reset_done),
    .magnet_en(magnet_en), .busy(busy), .batch_done(batch_done),
    .fifo_count(fifo_count), .error(error), .dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; home_req = 1'b0;
    motor_done = 1'b0; motor_reset_done = 1'b0;
    step(); step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push(input logic [2:0] d, input logic m, input logic l);
    int n;
    logic [7:0] one;
    n = 0;
    cmd_valid = 1'b1; cmd_dir = d; cmd_magnet = m; cmd_last = l;
    while (cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL push_accept: cmd_ready=%b required 1", cmd_ready); end
    step();
    cmd_valid = 1'b0;
    one = 8'h01 << d;
    exp_q.push_back(one);
  endtask

  // Caller is just after a posedge; cyc counts cycles until direction is seen.
  task automatic wait_dir(input int limit, output int cyc);
    cyc = 0;
    sample();
    while (direction == 8'h00 && cyc < limit) begin step(); sample(); cyc++; end
    checks++;
    if (direction == 8'h00) begin errors++; $display("FAIL dir_wait: no direction pulse within %0d cycles", limit); end
  endtask

  function automatic logic [7:0] next_exp();
    if (exp_q.size() == 0) return 8'h00;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    do_reset();
    sample();
    checks++; if (direction !== 8'h00) begin errors++; $display("FAIL rst_direction: got %h want 00", direction); end
    checks++; if (motor_reset !== 1'b0) begin errors++; $display("FAIL rst_motor_reset: got %b want 0", motor_reset); end
    checks++; if (magnet_en !== 1'b0) begin errors++; $display("FAIL rst_magnet: got %b want 0", magnet_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL rst_batch_done: got %b want 0", batch_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b want 0", error); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, IDLE); end
    step();
  endtask

  task automatic test_single();
    int c;
    logic [7:0] e;
    push(DIR_N, 1'b0, 1'b1);
    wait_dir(20, c);
    e = next_exp();
    checks++; if (c !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2 (cycles after push+1)", c); end
    checks++; if (direction !== e) begin errors++; $display("FAIL single_dir: got %h want %h", direction, e); end
    step(); sample();
    checks++; if (direction !== 8'h00) begin errors++; $display("FAIL single_width: got %h want 00", direction); end
    checks++; if (dbg_state !== WAIT_DONE) begin errors++; $display("FAIL single_wait: got %0d want %0d", dbg_state, WAIT_DONE); end
    repeat (9) step();
    motor_done = 1'b1;
    sample();
    checks++; if (batch_done !== 1'b1) begin errors++; $display("FAIL single_batch_done: got %b want 1", batch_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_hold: got %b want 1", busy); end
    step(); motor_done = 1'b0; sample();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL single_bd_width: got %b want 0", batch_done); end
    step();
  endtask

  task automatic test_magnet();
    int c;
    logic [7:0] e;
    push(DIR_NE, 1'b1, 1'b0);
    push(DIR_S, 1'b1, 1'b1);
    sample();
    checks++; if (magnet_en !== 1'b0 || dbg_state !== LOAD) begin errors++; $display("FAIL mag_load: magnet=%b state=%0d want 0/%0d", magnet_en, dbg_state, LOAD); end
    step(); sample();
    checks++; if (magnet_en !== 1'b1 || dbg_state !== MAG_SETTLE) begin errors++; $display("FAIL mag_rise: magnet=%b state=%0d want 1/%0d", magnet_en, dbg_state, MAG_SETTLE); end
    step();
    wait_dir(20, c);
    e = next_exp();
    checks++; if (c !== 3) begin errors++; $display("FAIL mag_settle_len: got %0d want 3", c); end
    checks++; if (direction !== e) begin errors++; $display("FAIL mag_first_dir: got %h want %h", direction, e); end
    step(); motor_done = 1'b1; sample();
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL mag_mid_bd: got %b want 0", batch_done); end
    step(); motor_done = 1'b0; sample();
    checks++; if (magnet_en !== 1'b1) begin errors++; $display("FAIL mag_hold: got %b want 1", magnet_en); end
    step(); sample();
    e = next_exp();
    checks++; if (direction !== e) begin errors++; $display("FAIL mag_second_dir: got %h want %h", direction, e); end
    step(); motor_done = 1'b1; sample();
    checks++; if (batch_done !== 1'b1) begin errors++; $display("FAIL mag_bd: got %b want 1", batch_done); end
    step(); motor_done = 1'b0; sample();
    checks++; if (magnet_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mag_off: magnet=%b busy=%b want 0/0", magnet_en, busy); end
    step();
  endtask

  task automatic test_fill();
    int acc, n, base;
    acc = 0; n = 0; base = dir_pulses;
    cmd_magnet = 1'b0; cmd_last = 1'b0;
    while (acc < 17 && n < 40) begin
      cmd_valid = 1'b1;
      cmd_dir = acc[2:0];
      if (cmd_ready) acc++;
      step(); n++;
    end
    cmd_dir = 3'd1;
    sample();
    checks++; if (acc !== 17 || n !== 17) begin errors++; $display("FAIL fill_accepts: got %0d in %0d cycles want 17 in 17", acc, n); end
    checks++; if (cmd_ready !== 1'b0 || fifo_count !== 5'd16) begin errors++; $display("FAIL fill_full: ready=%b count=%0d want 0/16", cmd_ready, fifo_count); end
    checks++; if (dir_pulses - base !== 1 || last_pulse !== 8'h01) begin errors++; $display("FAIL fill_first_pulse: n=%0d dir=%h want 1/01", dir_pulses - base, last_pulse); end
    repeat (3) begin
      step(); sample();
      checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL fill_hold: count=%0d want 16", fifo_count); end
    end
    step(); motor_done = 1'b1; sample();
    step(); motor_done = 1'b0; sample();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL fill_load_ready: got %b want 0", cmd_ready); end
    step(); sample();
    checks++; if (cmd_ready !== 1'b1 || fifo_count !== 5'd15) begin errors++; $display("FAIL fill_refill: ready=%b count=%0d want 1/15", cmd_ready, fifo_count); end
    checks++; if (direction !== 8'h02) begin errors++; $display("FAIL fill_second_dir: got %h want 02", direction); end
    step(); cmd_valid = 1'b0; sample();
    checks++; if (cmd_ready !== 1'b0 || fifo_count !== 5'd16) begin errors++; $display("FAIL fill_17th: ready=%b count=%0d want 0/16", cmd_ready, fifo_count); end
    do_reset(); sample();
    checks++; if (fifo_count !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL fill_reset: count=%0d busy=%b want 0/0", fifo_count, busy); end
    step();
  endtask

  task automatic test_home();
    int c, base;
    logic [7:0] e;
    logic bad;
    base = mreset_pulses;
    push(DIR_W, 1'b0, 1'b0);
    push(DIR_SE, 1'b0, 1'b0);
    push(DIR_E, 1'b0, 1'b1);
    wait_dir(20, c);
    e = next_exp();
    checks++; if (direction !== e || c !== 0) begin errors++; $display("FAIL home_first: dir=%h c=%0d want %h/0", direction, c, e); end
    step(); home_req = 1'b1; sample();
    step(); home_req = 1'b0;
    repeat (3) step();
    sample();
    checks++; if (dbg_state !== WAIT_DONE || mreset_pulses !== base) begin errors++; $display("FAIL home_no_interrupt: state=%0d pulses=%0d want %0d/%0d", dbg_state, mreset_pulses - base, WAIT_DONE, 0); end
    step(); motor_done = 1'b1; sample();
    checks++; if (batch_done !== 1'b0) begin errors++; $display("FAIL home_bd: got %b want 0", batch_done); end
    step(); motor_done = 1'b0; sample();
    checks++; if (motor_reset !== 1'b1 || dbg_state !== HOME) begin errors++; $display("FAIL home_pulse: mreset=%b state=%0d want 1/%0d", motor_reset, dbg_state, HOME); end
    step(); sample();
    checks++; if (motor_reset !== 1'b0 || dbg_state !== HOME_WAIT || fifo_count !== 5'd2) begin errors++; $display("FAIL home_wait: mreset=%b state=%0d count=%0d want 0/%0d/2", motor_reset, dbg_state, fifo_count, HOME_WAIT); end
    bad = 1'b0;
    repeat (5) begin step(); sample(); if (direction !== 8'h00 || dbg_state !== HOME_WAIT) bad = 1'b1; end
    checks++; if (bad) begin errors++; $display("FAIL home_hold: got a move or left HOME_WAIT, want none"); end
    step(); motor_reset_done = 1'b1;
    step(); motor_reset_done = 1'b0;
    wait_dir(20, c);
    e = next_exp();
    checks++; if (direction !== e || c !== 2) begin errors++; $display("FAIL home_resume: dir=%h c=%0d want %h/2", direction, c, e); end
    checks++; if (mreset_pulses - base !== 1) begin errors++; $display("FAIL home_once: got %0d pulses want 1", mreset_pulses - base); end
    step(); motor_done = 1'b1;
    step(); motor_done = 1'b0;
    step(); sample();
    e = next_exp();
    checks++; if (direction !== e) begin errors++; $display("FAIL home_third: got %h want %h", direction, e); end
    step(); motor_done = 1'b1; sample();
    checks++; if (batch_done !== 1'b1) begin errors++; $display("FAIL home_bd_last: got %b want 1", batch_done); end
    step(); motor_done = 1'b0; sample();
    checks++; if (busy !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL home_end: busy=%b count=%0d want 0/0", busy, fifo_count); end
    step();
  endtask

  task automatic test_reset_mid();
    int base;
    logic bad;
    push(DIR_SW, 1'b1, 1'b1);
    step(); step(); sample();
    checks++; if (dbg_state !== MAG_SETTLE) begin errors++; $display("FAIL rmid_state: got %0d want %0d", dbg_state, MAG_SETTLE); end
    step(); reset = 1'b1;
    step(); reset = 1'b0; motor_done = 1'b1;
    exp_q.delete();
    base = dir_pulses;
    sample();
    checks++; if (magnet_en !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0) begin errors++; $display("FAIL rmid_clear: magnet=%b busy=%b count=%0d want 0/0/0", magnet_en, busy, fifo_count); end
    checks++; if (cmd_ready !== 1'b1 || batch_done !== 1'b0 || error !== 1'b0 || motor_reset !== 1'b0) begin errors++; $display("FAIL rmid_outs: ready=%b bd=%b err=%b mreset=%b want 1/0/0/0", cmd_ready, batch_done, error, motor_reset); end
    step(); motor_done = 1'b0;
    bad = 1'b0;
    repeat (8) begin step(); sample(); if (busy !== 1'b0) bad = 1'b1; end
    checks++; if (bad || dir_pulses !== base) begin errors++; $display("FAIL rmid_quiet: busy_seen=%b pulses=%0d want 0/0", bad, dir_pulses - base); end
    step();
  endtask

`ifdef MOVE_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    push(DIR_W, 1'b1, 1'b0);
    wait_dir(30, c);
    checks++; if (direction !== 8'h04 || c !== 6) begin errors++; $display("FAIL to_dir: dir=%h c=%0d want 04/6", direction, c); end
    step();
    repeat (99) step();
    sample();
    checks++; if (error !== 1'b0 || dbg_state !== WAIT_DONE) begin errors++; $display("FAIL to_early: err=%b state=%0d want 0/%0d", error, dbg_state, WAIT_DONE); end
    step(); sample();
    checks++; if (error !== 1'b1 || dbg_state !== ERROR) begin errors++; $display("FAIL to_error: err=%b state=%0d want 1/%0d", error, dbg_state, ERROR); end
    checks++; if (cmd_ready !== 1'b0 || magnet_en !== 1'b0 || busy !== 1'b1 || direction !== 8'h00) begin errors++; $display("FAIL to_outs: ready=%b magnet=%b busy=%b dir=%h want 0/0/1/00", cmd_ready, magnet_en, busy, direction); end
    step(); motor_done = 1'b1;
    step(); motor_done = 1'b0;
    repeat (5) step();
    sample();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", error); end
    do_reset(); sample();
    checks++; if (error !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL to_cleared: err=%b ready=%b want 0/1", error, cmd_ready); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_magnet();
    test_fill();
    test_home();
    test_reset_mid();
`ifdef MOVE_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
